dma_stream_engine: RTL and testbench

Parametrised DMA transfer engine for the AFU: software supplies read/write base addresses, a cache-line count, a transform mode and a go pulse. The engine streams lines from the DMA read channel through a `PIPE_STAGES`-deep transform pipeline into the DMA write channel. It raises a sticky done and reports a cycle count. It sits between the memory map and the DMA interface, replacing fixed single-line loopback with multi-line, stall-aware transfers.

---
 rtl/dma_stream_pkg.sv | 5 +
 rtl/dma_stream_engine_stage.sv | 37 +++
 rtl/dma_stream_engine.sv | 122 ++++++++++++
 tb/tb_dma_stream_engine.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dma_stream_pkg.sv
// dma_stream_pkg: transform mode and FSM state encodings shared by the DMA stream engine
package dma_stream_pkg;
  typedef enum logic [1:0] {MODE_PASS = 2'b00, MODE_INV = 2'b01, MODE_ADD = 2'b10} mode_e;
  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/dma_stream_engine_stage.sv
// stream_transform_stage: one registered pipeline stage; stage 0 applies the line transform
// ports: clk/rst, i_en advance, i_valid/i_data in, i_mode/i_addend transform controls, o_valid/o_data registered out
module stream_transform_stage
  import dma_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int LANE_WIDTH = 32,
  parameter bit FIRST      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_mode,
  input  logic [LANE_WIDTH-1:0] i_addend,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic [DATA_WIDTH-1:0] w_add, w_xf;
  // lanes wrap independently: no carry crosses a lane boundary
  for (genvar l = 0; l < DATA_WIDTH / LANE_WIDTH; l++) begin : g_lane
    assign w_add[l*LANE_WIDTH +: LANE_WIDTH] = i_data[l*LANE_WIDTH +: LANE_WIDTH] + i_addend;
  end
  assign w_xf = !FIRST ? i_data :
                i_mode == MODE_INV ? ~i_data :
                i_mode == MODE_ADD ? w_add : i_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_data  <= w_xf;
    end
  end
endmodule

// File: rtl/dma_stream_engine.sv
// dma_stream_engine: streams cache lines from the DMA read channel through a transform pipeline into the write channel
// ports: go/addresses/size/mode/addend from the memory map; done/cycles status; dma_* read/write channel handshake
module dma_stream_engine
  import dma_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int LANE_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 64,
  parameter int SIZE_WIDTH  = 43,
  parameter int PIPE_STAGES = 2,
  parameter int CYC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [SIZE_WIDTH-1:0] size,
  input  logic [1:0]            mode,
  input  logic [LANE_WIDTH-1:0] addend,
  output logic                  done,
  output logic [CYC_WIDTH-1:0]  cycles,
  output logic [ADDR_WIDTH-1:0] dma_rd_addr,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr,
  output logic [SIZE_WIDTH-1:0] dma_rd_size,
  output logic [SIZE_WIDTH-1:0] dma_wr_size,
  output logic                  dma_rd_go,
  output logic                  dma_wr_go,
  input  logic                  dma_empty,
  input  logic                  dma_full,
  input  logic [DATA_WIDTH-1:0] dma_rd_data,
  output logic                  dma_rd_en,
  output logic                  dma_wr_en,
  output logic [DATA_WIDTH-1:0] dma_wr_data,
  input  logic                  dma_rd_done,
  input  logic                  dma_wr_done
);
  state_e                r_state;
  logic [SIZE_WIDTH-1:0] r_size, r_rd_cnt, r_wr_cnt;
  logic [1:0]            r_mode;
  logic [LANE_WIDTH-1:0] r_addend;
  logic [PIPE_STAGES:0]  w_vld;
  logic [DATA_WIDTH-1:0] w_dat [PIPE_STAGES+1];
  logic                  w_run, w_unused;
  assign w_unused    = dma_rd_done;
  assign w_run       = r_state == S_RUN;
  assign dma_rd_en   = w_run && !dma_empty && !dma_full && r_rd_cnt < r_size;
  assign dma_wr_en   = w_run && w_vld[PIPE_STAGES] && !dma_full;
  assign dma_wr_data = w_dat[PIPE_STAGES];
  assign dma_rd_size = r_size;
  assign dma_wr_size = r_size;
  assign w_vld[0]    = dma_rd_en;
  assign w_dat[0]    = dma_rd_data;
  // a full write FIFO freezes every stage so no line is dropped or duplicated
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    stream_transform_stage #(
      .DATA_WIDTH(DATA_WIDTH),
      .LANE_WIDTH(LANE_WIDTH),
      .FIRST     (s == 0)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (!dma_full),
      .i_valid (w_vld[s]),
      .i_data  (w_dat[s]),
      .i_mode  (r_mode),
      .i_addend(r_addend),
      .o_valid (w_vld[s+1]),
      .o_data  (w_dat[s+1])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_size      <= '0;
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_mode      <= '0;
      r_addend    <= '0;
      done        <= 1'b0;
      cycles      <= '0;
      dma_rd_addr <= '0;
      dma_wr_addr <= '0;
      dma_rd_go   <= 1'b0;
      dma_wr_go   <= 1'b0;
    end else begin
      dma_rd_go <= 1'b0;
      dma_wr_go <= 1'b0;
      // a zero-length transfer passes through START without counting
      if (((r_state == S_START && r_size != '0) || r_state == S_RUN || r_state == S_DRAIN) && cycles != '1)
        cycles <= cycles + 1'b1;
      if (dma_rd_en) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (dma_wr_en) r_wr_cnt <= r_wr_cnt + 1'b1;
      case (r_state)
        S_IDLE, S_DONE: if (go) begin
          r_state     <= S_START;
          r_size      <= size;
          r_mode      <= mode;
          r_addend    <= addend;
          r_rd_cnt    <= '0;
          r_wr_cnt    <= '0;
          done        <= 1'b0;
          cycles      <= '0;
          dma_rd_addr <= rd_addr_in;
          dma_wr_addr <= wr_addr_in;
          dma_rd_go   <= size != '0;
          dma_wr_go   <= size != '0;
        end
        S_START: begin
          r_state <= r_size == '0 ? S_DONE : S_RUN;
          done    <= r_size == '0;
        end
        S_RUN: if (dma_wr_en && r_wr_cnt == r_size - 1'b1) r_state <= S_DRAIN;
        S_DRAIN: if (dma_wr_done) begin
          r_state <= S_DONE;
          done    <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_stream_engine.sv
// tb_dma_stream_engine: directed and randomized transfers checked against a queue-based reference model
module tb_dma_stream_engine;
  localparam int DW = 128, LW = 32, AW = 64, SW = 16, PS = 2, CW = 5;
  localparam int CMAX = (1 << CW) - 1;
  logic          clk = 1'b0, rst = 1'b1, go = 1'b0;
  logic [AW-1:0] rd_addr_in = '0, wr_addr_in = '0;
  logic [SW-1:0] size = '0;
  logic [1:0]    mode = '0;
  logic [LW-1:0] addend = '0;
  logic          done;
  logic [CW-1:0] cycles;
  logic [AW-1:0] dma_rd_addr, dma_wr_addr;
  logic [SW-1:0] dma_rd_size, dma_wr_size;
  logic          dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en;
  logic          dma_empty = 1'b1, dma_full = 1'b0, dma_rd_done = 1'b0, dma_wr_done = 1'b0;
  logic [DW-1:0] dma_rd_data = '0, dma_wr_data;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  dma_stream_engine #(
    .DATA_WIDTH(DW), .LANE_WIDTH(LW), .ADDR_WIDTH(AW),
    .SIZE_WIDTH(SW), .PIPE_STAGES(PS), .CYC_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .rd_addr_in(rd_addr_in), .wr_addr_in(wr_addr_in),
    .size(size), .mode(mode), .addend(addend), .done(done), .cycles(cycles),
    .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr), .dma_rd_size(dma_rd_size),
    .dma_wr_size(dma_wr_size), .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go),
    .dma_empty(dma_empty), .dma_full(dma_full), .dma_rd_data(dma_rd_data),
    .dma_rd_en(dma_rd_en), .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data),
    .dma_rd_done(dma_rd_done), .dma_wr_done(dma_wr_done)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] xf(input logic [DW-1:0] d, input logic [1:0] m, input logic [LW-1:0] a);
    logic [DW-1:0] r;
    r = m == 2'b01 ? ~d : d;
    if (m == 2'b10)
      for (int i = 0; i < DW / LW; i++) r[i*LW +: LW] = d[i*LW +: LW] + a;
    return r;
  endfunction

  // pat: 0 random, 1 counting 1..n, 2 lane 0 all-ones, 3 all-zero
  task automatic xfer(input int n, input logic [1:0] m, input logic [LW-1:0] a, input int pat,
                      input int st_at, input int st_len, input bit rnd, input bit go_mid, input int rst_at);
    logic [DW-1:0] src[$], expq[$];
    logic [AW-1:0] ra, wa;
    int pops = 0, pushes = 0, rdgo = 0, wrgo = 0, viol = 0, first_rd = -1, first_wr = -1;
    int last_push = -1, wd_t = -1, done_t = -1, quiet = 0, exp_done, exp_cyc;
    int dly = int'($urandom_range(0, 2));
    ra = {$urandom, $urandom};
    wa = {$urandom, $urandom};
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      if (pat == 1) d = DW'(i + 1);
      else if (pat == 2) d[LW-1:0] = '1;
      else if (pat == 3) d = '0;
      src.push_back(d);
      expq.push_back(xf(d, m, a));
    end
    @(posedge clk); #1;
    go = 1'b1; rd_addr_in = ra; wr_addr_in = wa; size = SW'(n); mode = m; addend = a;
    @(posedge clk); #1;
    go = 1'b0; rd_addr_in = ~ra; wr_addr_in = ~wa; size = SW'(n + 1); mode = ~m; addend = ~a;
    for (int t = 0; t < 400; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      dma_full  = (t >= st_at && t < st_at + st_len) || (rnd && $urandom_range(0, 3) == 0);
      dma_empty = rnd && $urandom_range(0, 4) == 0;
      dma_rd_data = pops < n ? src[pops] : {$urandom, $urandom, $urandom, $urandom};
      if (n > 0 && last_push >= 0 && t > last_push + dly && !dma_wr_done) begin
        dma_wr_done = 1'b1;
        wd_t = t;
      end
      if (go_mid && t == 3) begin go = 1'b1; size = SW'(n + 5); end else go = 1'b0;
      @(negedge clk);
      if (t == 0) chk("done_cleared_on_go", DW'(done), '0);
      if (dma_rd_go) rdgo++;
      if (dma_wr_go) wrgo++;
      if (dma_full && (dma_rd_en || dma_wr_en)) viol++;
      if (dma_rd_en) begin
        if (first_rd < 0) first_rd = t;
        pops++;
      end
      if (dma_wr_en) begin
        if (first_wr < 0) first_wr = t;
        if (pushes < n) chk($sformatf("wr_data[%0d]", pushes), dma_wr_data, expq[pushes]);
        pushes++;
        if (pushes == n) last_push = t;
      end
      if (rst_at >= 0 && pushes == rst_at) break;
      if (done) begin done_t = t; break; end
    end
    go = 1'b0;
    dma_wr_done = 1'b0;
    if (rst_at >= 0) begin
      @(posedge clk); #1;
      rst = 1'b1; dma_full = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_ctl", DW'({dma_rd_en, dma_wr_en, dma_rd_go, dma_wr_go, done, cycles}), '0);
      chk("rst_addr", DW'({dma_rd_addr, dma_wr_addr}), '0);
      chk("rst_size", DW'({dma_rd_size, dma_wr_size}), '0);
      chk("rst_wr_data", dma_wr_data, '0);
      rst = 1'b0;
      repeat (4) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (dma_wr_en || dma_rd_en) quiet++;
      end
      chk("post_rst_quiet", DW'(quiet), '0);
      return;
    end
    exp_done = n == 0 ? 1 : wd_t + 1;
    exp_cyc  = n == 0 ? 0 : (done_t > CMAX ? CMAX : done_t);
    chk("done_reached", DW'(done_t >= 0), DW'(1));
    chk("done_time", DW'(done_t), DW'(exp_done));
    chk("pops", DW'(pops), DW'(n));
    chk("pushes", DW'(pushes), DW'(n));
    chk("rd_go_pulses", DW'(rdgo), DW'(n > 0));
    chk("wr_go_pulses", DW'(wrgo), DW'(n > 0));
    chk("en_while_full", DW'(viol), '0);
    chk("cycles", DW'(cycles), DW'(exp_cyc));
    chk("rd_addr", DW'(dma_rd_addr), DW'(ra));
    chk("wr_addr", DW'(dma_wr_addr), DW'(wa));
    chk("sizes", DW'({dma_rd_size, dma_wr_size}), DW'({SW'(n), SW'(n)}));
    if (!rnd && st_len == 0 && n > 0) chk("rd_to_wr_latency", DW'(first_wr - first_rd), DW'(PS));
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_sticky", DW'(done), DW'(1));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ctl", DW'({dma_rd_en, dma_wr_en, dma_rd_go, dma_wr_go, done}), '0);
    chk("reset_cycles", DW'(cycles), '0);
    chk("reset_addr", DW'({dma_rd_addr, dma_wr_addr}), '0);
    rst = 1'b0;
    xfer(4, 2'b00, '0, 1, 0, 0, 1'b0, 1'b0, -1);
    xfer(3, 2'b10, LW'(1), 2, 0, 0, 1'b0, 1'b0, -1);
    xfer(3, 2'b01, '0, 3, 0, 0, 1'b0, 1'b0, -1);
    xfer(8, 2'b00, '0, 0, 5, 5, 1'b0, 1'b0, -1);
    xfer(0, 2'b00, '0, 0, 0, 0, 1'b0, 1'b0, -1);
    xfer(6, 2'b11, '0, 0, 0, 0, 1'b0, 1'b1, -1);
    xfer(6, 2'b10, $urandom, 0, 0, 0, 1'b0, 1'b0, 2);
    xfer(2, 2'b10, $urandom, 0, 0, 0, 1'b0, 1'b0, -1);
    for (int k = 0; k < 4; k++)
      xfer(int'($urandom_range(1, 10)), 2'($urandom_range(0, 3)), $urandom, 0, 0, 0, 1'b1, 1'b0, -1);
    xfer(30, 2'b10, $urandom, 0, 0, 0, 1'b1, 1'b0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
